uctl_dmarx_sched: RTL and testbench

Round-robin scheduler that shares the single DMA Rx engine (local buffer → system memory) between NUM_EP endpoint request channels. It latches one endpoint's transfer descriptor and drives the engine's start/address/length inputs. It holds `dmaStart` until the engine reports done, then pulses a per-endpoint completion. It sits between the per-endpoint system endpoint controller logic and the DMA Rx engine.

---
 rtl/uctl_dma_pkg.sv | 14 +
 rtl/uctl_rrArb.sv | 31 +++
 rtl/uctl_dmarx_sched.sv | 154 +++++++++++++++
 tb/tb_uctl_dmarx_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uctl_dma_pkg.sv
// Shared DMA scheduler definitions: FSM state encoding and default bus widths.
// Combinational constants only; no latency or flow control of its own.
package uctl_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_CMPL = 2'b10
   } sch_state_e;

   localparam int CNTR_WD_DFLT   = 20;
   localparam int ADDR_SIZE_DFLT = 32;

endpackage

// File: rtl/uctl_rrArb.sv
// Round-robin priority search: first requester at or after rr_ptr_i, wrapping.
// Purely combinational (zero latency); the pointer register lives in the parent.
module uctl_rrArb #(
   parameter int NUM_EP    = 4,
   parameter int EP_IDX_WD = $clog2(NUM_EP)
) (
   input  logic [NUM_EP-1:0]    req_i,
   input  logic [EP_IDX_WD-1:0] rr_ptr_i,
   output logic                 gnt_vld_o,
   output logic [EP_IDX_WD-1:0] gnt_idx_o
);

   int idx;

   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      idx       = 0;
      for (int k = 0; k < NUM_EP; k++) begin
         idx = int'(rr_ptr_i) + k;
         if (idx >= NUM_EP) begin
            idx = idx - NUM_EP;
         end
         if (!gnt_vld_o && req_i[idx]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = EP_IDX_WD'(idx);
         end
      end
   end

endmodule

// File: rtl/uctl_dmarx_sched.sv
// Shares the DMA Rx engine between endpoints; grant->dmaStart in 1 cycle, engine done->ep dn in 1 cycle.
// Holds dmaStart and a frozen descriptor until the engine reports done; other requesters wait.
module uctl_dmarx_sched
   import uctl_dma_pkg::*;
#(
   parameter int NUM_EP    = 4,
   parameter int CNTR_WD   = CNTR_WD_DFLT,
   parameter int ADDR_SIZE = ADDR_SIZE_DFLT,
   localparam int EP_IDX_WD = $clog2(NUM_EP)
) (
   input  logic                        core_clk,
   input  logic                        uctl_rst_n,
   input  logic                        sw_rst,
   input  logic [NUM_EP-1:0]           ep2sch_req,
   input  logic [NUM_EP*ADDR_SIZE-1:0] ep2sch_sWrAddr,
   input  logic [NUM_EP*ADDR_SIZE-1:0] ep2sch_laddr,
   input  logic [NUM_EP*CNTR_WD-1:0]   ep2sch_len,
   input  logic [NUM_EP*ADDR_SIZE-1:0] ep2sch_epStartAddr,
   input  logic [NUM_EP*ADDR_SIZE-1:0] ep2sch_epEndAddr,
   output logic [NUM_EP-1:0]           sch2ep_dn,
   output logic                        sch2dmaRx_dmaStart,
   output logic [ADDR_SIZE-1:0]        sch2dmaRx_sWrAddr,
   output logic [ADDR_SIZE-1:0]        sch2dmaRx_laddrIn,
   output logic [ADDR_SIZE-1:0]        sch2dmaRx_epStartAddr,
   output logic [ADDR_SIZE-1:0]        sch2dmaRx_epEndAddr,
   output logic [CNTR_WD-1:0]          sch2dmaRx_len,
   output logic                        sch2dmaRx_sRdWr,
   input  logic                        dmaRx2sch_dn,
   output logic                        sch2reg_busy,
   output logic [EP_IDX_WD-1:0]        sch2reg_curEp
);

   sch_state_e             state_q, state_d;
   logic [EP_IDX_WD-1:0]   rr_ptr_q, rr_ptr_d;
   logic [EP_IDX_WD-1:0]   cur_ep_q, cur_ep_d;
   logic                   start_q, start_d;
   logic                   busy_q, busy_d;
   logic [NUM_EP-1:0]      dn_q, dn_d;
   logic [ADDR_SIZE-1:0]   swr_q, swr_d, laddr_q, laddr_d;
   logic [ADDR_SIZE-1:0]   st_q, st_d, end_q, end_d;
   logic [CNTR_WD-1:0]     len_q, len_d;

   logic                   gnt_vld;
   logic [EP_IDX_WD-1:0]   gnt_idx;
   logic [CNTR_WD-1:0]     gnt_len;

   uctl_rrArb #(
      .NUM_EP    (NUM_EP),
      .EP_IDX_WD (EP_IDX_WD)
   ) u_rrArb (
      .req_i     (ep2sch_req),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   assign gnt_len = ep2sch_len[gnt_idx*CNTR_WD +: CNTR_WD];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      cur_ep_d = cur_ep_q;
      start_d  = start_q;
      dn_d     = '0;
      swr_d    = swr_q;
      laddr_d  = laddr_q;
      st_d     = st_q;
      end_d    = end_q;
      len_d    = len_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               cur_ep_d = gnt_idx;
               swr_d    = ep2sch_sWrAddr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
               laddr_d  = ep2sch_laddr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
               st_d     = ep2sch_epStartAddr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
               end_d    = ep2sch_epEndAddr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
               len_d    = gnt_len;
               state_d  = ST_RUN;
               start_d  = (gnt_len != '0);
            end
         end
         ST_RUN: begin
            // Zero-length grants pass through RUN with the engine left idle.
            if (len_q == '0) begin
               state_d = ST_CMPL;
               dn_d    = NUM_EP'(1) << cur_ep_q;
            end else if (dmaRx2sch_dn) begin
               start_d = 1'b0;
               state_d = ST_CMPL;
               dn_d    = NUM_EP'(1) << cur_ep_q;
            end
         end
         ST_CMPL: begin
            rr_ptr_d = (cur_ep_q == EP_IDX_WD'(NUM_EP-1)) ? '0 : cur_ep_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (sw_rst) begin
         state_d  = ST_IDLE;
         rr_ptr_d = '0;
         cur_ep_d = '0;
         start_d  = 1'b0;
         dn_d     = '0;
         swr_d    = '0;
         laddr_d  = '0;
         st_d     = '0;
         end_d    = '0;
         len_d    = '0;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge core_clk or negedge uctl_rst_n) begin
      if (!uctl_rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         cur_ep_q <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         dn_q     <= '0;
         swr_q    <= '0;
         laddr_q  <= '0;
         st_q     <= '0;
         end_q    <= '0;
         len_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cur_ep_q <= cur_ep_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
         dn_q     <= dn_d;
         swr_q    <= swr_d;
         laddr_q  <= laddr_d;
         st_q     <= st_d;
         end_q    <= end_d;
         len_q    <= len_d;
      end
   end

   assign sch2ep_dn             = dn_q;
   assign sch2dmaRx_dmaStart    = start_q;
   assign sch2dmaRx_sWrAddr     = swr_q;
   assign sch2dmaRx_laddrIn     = laddr_q;
   assign sch2dmaRx_epStartAddr = st_q;
   assign sch2dmaRx_epEndAddr   = end_q;
   assign sch2dmaRx_len         = len_q;
   assign sch2dmaRx_sRdWr       = 1'b1;
   assign sch2reg_busy          = busy_q;
   assign sch2reg_curEp         = cur_ep_q;

endmodule

// File: tb/tb_uctl_dmarx_sched.sv
// Bench for uctl_dmarx_sched: acts as endpoints and DMA engine, scoreboards grants/completions.
module tb_uctl_dmarx_sched;

   localparam int NEP = 4;
   localparam int CW  = 20;
   localparam int AW  = 32;

   typedef struct {
      int             ep;
      logic [AW-1:0]  sw;
      logic [AW-1:0]  la;
      logic [CW-1:0]  len;
      logic [AW-1:0]  st;
      logic [AW-1:0]  en;
   } exp_t;

   logic              core_clk, uctl_rst_n, sw_rst;
   logic [NEP-1:0]    ep2sch_req;
   logic [NEP*AW-1:0] ep_sw, ep_la, ep_st, ep_en;
   logic [NEP*CW-1:0] ep_len;
   logic [NEP-1:0]    sch2ep_dn;
   logic              dma_start, s_rd_wr, dma_dn, busy;
   logic [AW-1:0]     o_sw, o_la, o_st, o_en;
   logic [CW-1:0]     o_len;
   logic [1:0]        cur_ep;

   exp_t sb[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   int   last_dn_cyc = -1;

   uctl_dmarx_sched dut (
      .core_clk              (core_clk),
      .uctl_rst_n            (uctl_rst_n),
      .sw_rst                (sw_rst),
      .ep2sch_req            (ep2sch_req),
      .ep2sch_sWrAddr        (ep_sw),
      .ep2sch_laddr          (ep_la),
      .ep2sch_len            (ep_len),
      .ep2sch_epStartAddr    (ep_st),
      .ep2sch_epEndAddr      (ep_en),
      .sch2ep_dn             (sch2ep_dn),
      .sch2dmaRx_dmaStart    (dma_start),
      .sch2dmaRx_sWrAddr     (o_sw),
      .sch2dmaRx_laddrIn     (o_la),
      .sch2dmaRx_epStartAddr (o_st),
      .sch2dmaRx_epEndAddr   (o_en),
      .sch2dmaRx_len         (o_len),
      .sch2dmaRx_sRdWr       (s_rd_wr),
      .dmaRx2sch_dn          (dma_dn),
      .sch2reg_busy          (busy),
      .sch2reg_curEp         (cur_ep)
   );

   initial begin
      core_clk = 1'b0;
      forever #5 core_clk = ~core_clk;
   end

   always @(posedge core_clk) cyc <= cyc + 1;

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk_desc(input int ep, input int salt);
      exp_t e;
      e.ep  = ep;
      e.sw  = 32'h8000_0000 + 32'(ep * 32'h1000) + 32'(salt);
      e.la  = 32'(ep * 32'h100) + 32'(salt * 4);
      e.len = CW'(16 * (ep + 1) + salt);
      e.st  = 32'(ep * 32'h400);
      e.en  = 32'(ep * 32'h400 + 32'h3ff) + 32'(salt);
      return e;
   endfunction

   task automatic set_ep(input exp_t e);
      ep_sw[e.ep*AW +: AW]  = e.sw;
      ep_la[e.ep*AW +: AW]  = e.la;
      ep_len[e.ep*CW +: CW] = e.len;
      ep_st[e.ep*AW +: AW]  = e.st;
      ep_en[e.ep*AW +: AW]  = e.en;
   endtask

   task automatic chk_desc(input string pfx, input exp_t e);
      chk_val({pfx, "_curEp"}, cur_ep, e.ep);
      chk_val({pfx, "_sWrAddr"}, o_sw, e.sw);
      chk_val({pfx, "_laddr"}, o_la, e.la);
      chk_val({pfx, "_len"}, o_len, e.len);
      chk_val({pfx, "_epStart"}, o_st, e.st);
      chk_val({pfx, "_epEnd"}, o_en, e.en);
   endtask

   task automatic chk_idle_outs(input string pfx);
      chk_val({pfx, "_start"}, dma_start, 0);
      chk_val({pfx, "_busy"}, busy, 0);
      chk_val({pfx, "_dn"}, sch2ep_dn, 0);
      chk_val({pfx, "_curEp"}, cur_ep, 0);
      chk_val({pfx, "_len"}, o_len, 0);
      chk_val({pfx, "_sWrAddr"}, o_sw, 0);
      chk_val({pfx, "_sRdWr"}, s_rd_wr, 1);
   endtask

   // Engine model: wait for start, hold for lat cycles, pulse done, check the completion.
   task automatic serve(input int lat);
      exp_t e;
      int   waited;
      waited = 0;
      while (!dma_start && waited < 50) begin
         @(negedge core_clk);
         waited++;
      end
      chk_val("start_seen", dma_start, 1);
      chk_val("sb_nonempty", sb.size() != 0, 1);
      if (!dma_start || sb.size() == 0) return;
      e = sb[0];
      if (last_dn_cyc >= 0) chk_val("restart_gap_ge3", (cyc - last_dn_cyc) >= 3, 1);
      chk_desc("grant", e);
      chk_val("busy_run", busy, 1);
      repeat (lat) @(negedge core_clk);
      chk_desc("hold", e);
      chk_val("start_held", dma_start, 1);
      dma_dn = 1'b1;
      last_dn_cyc = cyc;
      @(negedge core_clk);
      dma_dn = 1'b0;
      chk_val("ep_dn_pulse", sch2ep_dn, 64'(1) << e.ep);
      chk_val("start_clr", dma_start, 0);
      chk_val("busy_cmpl", busy, 1);
      void'(sb.pop_front());
      @(negedge core_clk);
      chk_val("ep_dn_single", sch2ep_dn, 0);
      chk_val("busy_idle", busy, 0);
   endtask

   initial begin
      exp_t e;
      uctl_rst_n = 1'b0;
      sw_rst     = 1'b0;
      ep2sch_req = '0;
      dma_dn     = 1'b0;
      ep_sw = '0; ep_la = '0; ep_st = '0; ep_en = '0; ep_len = '0;
      repeat (3) @(negedge core_clk);
      chk_idle_outs("reset");
      uctl_rst_n = 1'b1;
      @(negedge core_clk);

      // Round robin: all four request continuously -> 0,1,2,3,0.
      for (int i = 0; i < NEP; i++) set_ep(mk_desc(i, 0));
      sb.push_back(mk_desc(0, 0));
      sb.push_back(mk_desc(1, 0));
      sb.push_back(mk_desc(2, 0));
      sb.push_back(mk_desc(3, 0));
      sb.push_back(mk_desc(0, 0));
      ep2sch_req = 4'b1111;
      for (int n = 0; n < 5; n++) serve(n + 1);
      ep2sch_req = '0;
      @(negedge core_clk);

      // Single request EP1: len=64, laddr=0x100, sWrAddr=0x8000_0000.
      e = mk_desc(1, 0);
      e.len = 20'd64; e.la = 32'h100; e.sw = 32'h8000_0000;
      set_ep(e);
      sb.push_back(e);
      ep2sch_req = 4'b0010;
      chk_val("single_pre_start", dma_start, 0);
      @(negedge core_clk);
      chk_val("single_latency", dma_start, 1);
      serve(2);
      ep2sch_req = '0;
      @(negedge core_clk);

      // Zero length on EP2: engine never starts, dn at T+2.
      e = mk_desc(2, 0);
      e.len = '0;
      set_ep(e);
      sb.push_back(e);
      ep2sch_req = 4'b0100;
      @(negedge core_clk);
      chk_val("zl_t1_start", dma_start, 0);
      chk_val("zl_t1_busy", busy, 1);
      chk_val("zl_t1_dn", sch2ep_dn, 0);
      @(negedge core_clk);
      chk_val("zl_t2_dn", sch2ep_dn, 4'b0100);
      chk_val("zl_t2_start", dma_start, 0);
      chk_val("zl_sb_ep", sb[0].ep, 2);
      void'(sb.pop_front());
      @(negedge core_clk);
      ep2sch_req = '0;
      chk_val("zl_t3_dn", sch2ep_dn, 0);
      @(negedge core_clk);
      chk_val("zl_t4_start", dma_start, 0);
      chk_val("zl_t4_busy", busy, 0);

      // Descriptor stability: EP0 inputs change while RUN.
      e = mk_desc(0, 5);
      set_ep(e);
      sb.push_back(e);
      ep2sch_req = 4'b0001;
      @(negedge core_clk);
      set_ep(mk_desc(0, 9));
      serve(3);
      ep2sch_req = '0;
      @(negedge core_clk);
      chk_val("stable_idle_len", o_len, e.len);
      chk_val("stable_idle_sw", o_sw, e.sw);
      sb.push_back(mk_desc(0, 9));
      ep2sch_req = 4'b0001;
      serve(1);
      ep2sch_req = '0;
      @(negedge core_clk);

      // Soft reset mid-RUN, coincident with engine done: no dn pulse.
      set_ep(mk_desc(0, 2));
      ep2sch_req = 4'b0001;
      @(negedge core_clk);
      chk_val("swr_run_start", dma_start, 1);
      @(negedge core_clk);
      sw_rst = 1'b1;
      dma_dn = 1'b1;
      @(negedge core_clk);
      sw_rst = 1'b0;
      dma_dn = 1'b0;
      chk_idle_outs("swrst");
      ep2sch_req = 4'b1000;
      e = mk_desc(3, 1);
      set_ep(e);
      sb.push_back(e);
      @(negedge core_clk);
      chk_val("swrst_dn_none", sch2ep_dn, 0);
      serve(2);
      ep2sch_req = '0;
      @(negedge core_clk);

      // Async reset during RUN, seen without a clock edge.
      set_ep(mk_desc(1, 3));
      ep2sch_req = 4'b0010;
      @(negedge core_clk);
      chk_val("arst_run_start", dma_start, 1);
      #2 uctl_rst_n = 1'b0;
      #1 chk_idle_outs("arst");
      ep2sch_req = '0;
      @(negedge core_clk);
      uctl_rst_n = 1'b1;
      @(negedge core_clk);
      dma_dn = 1'b1;
      @(negedge core_clk);
      dma_dn = 1'b0;
      chk_val("spur_dn", sch2ep_dn, 0);
      chk_val("spur_busy", busy, 0);
      @(negedge core_clk);
      chk_val("spur_dn2", sch2ep_dn, 0);
      chk_val("spur_start", dma_start, 0);

      chk_val("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
